// File: rtl/cpu_pkg.sv
// Shared types and constants for the branch resolution path.
package cpu_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } br_state_e;

    localparam logic [1:0]  CNT_WNT   = 2'b01;
    localparam logic [31:0] PC_STEP_C = 32'd2;
    localparam logic [31:0] PC_STEP_I = 32'd4;

    // Saturating 2-bit counter step: never wraps past 3 or below 0.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// IF-hint, EX-resolution and redirect signals bundled between pipeline and resolver.
interface branch_resolver_if;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic        if_is_jal;
    logic        predict_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_compress;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output if_pc, if_is_branch, if_is_jal,
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_compress,
        output ex_pc, ex_target, ex_taken, ex_pred_taken,
        input  predict_taken, redirect, redirect_pc, flush,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, if_is_branch, if_is_jal,
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_compress,
        input  ex_pc, ex_target, ex_taken, ex_pred_taken,
        output predict_taken, redirect, redirect_pc, flush,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating direction counters: async read, sync update, parallel reset.
module bht_2bit
    import cpu_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] cnt_q [BHT_ENTRIES];
    logic [1:0] cnt_d [BHT_ENTRIES];

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_entry
            assign cnt_d[gi] = (upd_en_i && upd_idx_i == IDX_W'(gi))
                             ? sat_update(cnt_q[gi], upd_taken_i)
                             : cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // No bypass: a same-cycle update is not seen by the read.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_resolver.sv
// Resolves EX-stage branches/jumps against the IF prediction and drives redirect/flush.
module branch_resolver
    import cpu_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolver_if.slave   bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    br_state_e   state_q;
    logic        redirect_q;
    logic        flush_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    logic        resolve;
    logic        br_resolve;
    logic        jal_resolve;
    logic        actual_taken;
    logic        mispredict;
    logic [31:0] correct_pc_d;
    logic [1:0]  if_cnt;
    logic        unused_if_pc;

    bht_2bit #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (bus.if_pc[IDX_W:1]),
        .rd_cnt_o    (if_cnt),
        .upd_en_i    (br_resolve),
        .upd_idx_i   (bus.ex_pc[IDX_W:1]),
        .upd_taken_i (bus.ex_taken)
    );

    assign unused_if_pc = ^{bus.if_pc[31:IDX_W+1], bus.if_pc[0]};

    assign bus.predict_taken = bus.if_is_jal | (bus.if_is_branch & if_cnt[1]);

    // Jump takes priority if both type flags are set; jumps are always taken.
    assign resolve      = bus.ex_valid && (state_q == NORMAL);
    assign jal_resolve  = resolve && bus.ex_is_jal;
    assign br_resolve   = resolve && bus.ex_is_branch && !bus.ex_is_jal;
    assign actual_taken = bus.ex_is_jal | bus.ex_taken;
    assign mispredict   = (br_resolve || jal_resolve) && (actual_taken != bus.ex_pred_taken);
    assign correct_pc_d = actual_taken ? bus.ex_target
                        : bus.ex_pc + (bus.ex_is_compress ? PC_STEP_C : PC_STEP_I);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= NORMAL;
            redirect_q         <= 1'b0;
            flush_q            <= 1'b0;
            redirect_pc_q      <= 32'd0;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (br_resolve) begin
                        branch_count_q <= branch_count_q + 32'd1;
                        if (mispredict) begin
                            mispredict_count_q <= mispredict_count_q + 32'd1;
                        end
                    end
                    if (mispredict) begin
                        state_q       <= REDIRECT;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= correct_pc_d;
                    end
                end
                REDIRECT: begin
                    state_q    <= DRAIN;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b1;
                end
                DRAIN: begin
                    state_q <= NORMAL;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q    <= NORMAL;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.redirect         = redirect_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: prediction, redirect timing, wrap and reset recovery.
module tb_branch_resolver;

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    branch_resolver_if bus ();

    branch_resolver #(.BHT_ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic is_br, input logic is_jal, input logic cmp,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic taken, input logic pred);
        bus.ex_valid       = 1'b1;
        bus.ex_is_branch   = is_br;
        bus.ex_is_jal      = is_jal;
        bus.ex_is_compress = cmp;
        bus.ex_pc          = pc;
        bus.ex_target      = tgt;
        bus.ex_taken       = taken;
        bus.ex_pred_taken  = pred;
    endtask

    task automatic ex_idle();
        bus.ex_valid     = 1'b0;
        bus.ex_is_branch = 1'b0;
        bus.ex_is_jal    = 1'b0;
    endtask

    task automatic if_read(input logic [31:0] pc, input logic br, input logic jal);
        bus.if_pc        = pc;
        bus.if_is_branch = br;
        bus.if_is_jal    = jal;
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        bus.if_pc = 32'd0; bus.if_is_branch = 1'b0; bus.if_is_jal = 1'b0;
        bus.ex_is_compress = 1'b0; bus.ex_pc = 32'd0; bus.ex_target = 32'd0;
        bus.ex_taken = 1'b0; bus.ex_pred_taken = 1'b0;
        ex_idle();
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_redirect", {31'd0, bus.redirect}, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_rpc", bus.redirect_pc, 32'd0);
        check("rst_bcount", bus.branch_count, 32'd0);
        check("rst_mcount", bus.mispredict_count, 32'd0);
        if_read(32'h100, 1'b1, 1'b0);
        check("rst_pred_br", {31'd0, bus.predict_taken}, 32'd0);
        if_read(32'h100, 1'b0, 1'b1);
        check("rst_pred_jal", {31'd0, bus.predict_taken}, 32'd1);

        // Two correctly predicted taken branches at 0x100: counter 01 -> 10 -> 11
        ex_drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 1'b1, 1'b1);
        step();
        check("A_redirect", {31'd0, bus.redirect}, 32'd0);
        check("A_bcount", bus.branch_count, 32'd1);
        step();
        ex_idle();
        check("B_redirect", {31'd0, bus.redirect}, 32'd0);
        check("B_bcount", bus.branch_count, 32'd2);
        if_read(32'h100, 1'b1, 1'b0);
        check("B_pred", {31'd0, bus.predict_taken}, 32'd1);

        // Two more taken (saturate at 11), then a not-taken mispredict (11 -> 10)
        ex_drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 1'b1, 1'b1);
        step(); step();
        ex_drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 1'b0, 1'b1);
        step();
        ex_idle();
        check("E_redirect", {31'd0, bus.redirect}, 32'd1);
        check("E_rpc", bus.redirect_pc, 32'h104);
        check("E_mcount", bus.mispredict_count, 32'd1);
        check("E_bcount", bus.branch_count, 32'd5);
        step();
        check("E_drain_redirect", {31'd0, bus.redirect}, 32'd0);
        check("E_drain_flush", {31'd0, bus.flush}, 32'd1);
        step();
        check("E_normal_flush", {31'd0, bus.flush}, 32'd0);
        if_read(32'h100, 1'b1, 1'b0);
        check("E_pred_still_taken", {31'd0, bus.predict_taken}, 32'd1);

        // Compressed not-taken mispredict at 0x20 (shares idx 0: 10 -> 01)
        ex_drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h80, 1'b0, 1'b1);
        step();
        ex_idle();
        check("F_redirect", {31'd0, bus.redirect}, 32'd1);
        check("F_flush", {31'd0, bus.flush}, 32'd1);
        check("F_rpc", bus.redirect_pc, 32'h22);
        check("F_mcount", bus.mispredict_count, 32'd2);
        step();
        check("F_redirect2", {31'd0, bus.redirect}, 32'd0);
        check("F_flush2", {31'd0, bus.flush}, 32'd1);
        step();
        check("F_flush3", {31'd0, bus.flush}, 32'd0);

        // Taken mispredict at 0x40 (idx 0: 01 -> 10), then a masked mispredict in DRAIN
        ex_drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h400, 1'b1, 1'b0);
        step();
        ex_idle();
        check("G_redirect", {31'd0, bus.redirect}, 32'd1);
        check("G_rpc", bus.redirect_pc, 32'h400);
        check("G_bcount", bus.branch_count, 32'd7);
        step();
        ex_drive(1'b1, 1'b0, 1'b0, 32'h44, 32'h500, 1'b0, 1'b1);
        step();
        ex_idle();
        check("G_drain_redirect", {31'd0, bus.redirect}, 32'd0);
        check("G_drain_flush", {31'd0, bus.flush}, 32'd0);
        check("G_drain_bcount", bus.branch_count, 32'd7);
        check("G_drain_mcount", bus.mispredict_count, 32'd3);
        step();
        check("G_after_redirect", {31'd0, bus.redirect}, 32'd0);

        // Not-taken compressed mispredict at top of address space wraps to 0
        ex_drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h10, 1'b0, 1'b1);
        step();
        ex_idle();
        check("H_redirect", {31'd0, bus.redirect}, 32'd1);
        check("H_rpc_wrap", bus.redirect_pc, 32'h0000_0000);
        check("H_bcount", bus.branch_count, 32'd8);
        step(); step();

        // Jump arriving with pred=0 still redirects to its target
        ex_drive(1'b0, 1'b1, 1'b0, 32'h300, 32'h800, 1'b0, 1'b0);
        step();
        ex_idle();
        check("I_redirect", {31'd0, bus.redirect}, 32'd1);
        check("I_rpc", bus.redirect_pc, 32'h800);
        check("I_bcount", bus.branch_count, 32'd8);
        step(); step();

        // idx 0 currently weakly taken; a reset in REDIRECT must clear everything
        if_read(32'h0, 1'b1, 1'b0);
        check("J_pred_before_rst", {31'd0, bus.predict_taken}, 32'd1);
        ex_drive(1'b1, 1'b0, 1'b0, 32'h42, 32'h90, 1'b0, 1'b1);
        step();
        ex_idle();
        check("J_redirect", {31'd0, bus.redirect}, 32'd1);
        check("J_rpc", bus.redirect_pc, 32'h46);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("J_rst_redirect", {31'd0, bus.redirect}, 32'd0);
        check("J_rst_flush", {31'd0, bus.flush}, 32'd0);
        check("J_rst_bcount", bus.branch_count, 32'd0);
        check("J_rst_mcount", bus.mispredict_count, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if_read(32'(i * 2), 1'b1, 1'b0);
            check($sformatf("J_rst_bht%0d", i), {31'd0, bus.predict_taken}, 32'd0);
        end
        step();
        check("J_post_flush", {31'd0, bus.flush}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
